// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: drains a 32-bit word FIFO with one-cycle read latency and serialises each word
// onto a valid/ready byte stream. Byte order is LSB first; define UNPACK_MSB_FIRST_EN for MSB first.
module fifo_byte_unpacker #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [31:0]        fifo_data,
    output logic               fifo_read,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] word_count
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WORD_W-1:0]  shift_q, shift_d, shift_adv;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               valid_q, busy_q;
    logic               read_c;

    // The presented byte always sits at one end of the shift register; each accepted byte shifts it out.
`ifdef UNPACK_MSB_FIRST_EN
    assign shift_adv = {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
    assign out_data  = shift_q[WORD_W-1 -: BYTE_W];
`else
    assign shift_adv = {BYTE_W'(0), shift_q[WORD_W-1:BYTE_W]};
    assign out_data  = shift_q[BYTE_W-1:0];
`endif

    // Next-state logic; the read strobe is the only combinational output.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        count_d = count_q;
        read_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    read_c  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d = fifo_data;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    shift_d = shift_adv;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(3)) begin
                        count_d = count_q + COUNT_W'(1);
                        if (!fifo_empty) begin
                            read_c  = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            valid_q <= (state_d == ST_SEND);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // The FIFO shares the reset net; keep the strobe quiet while it is held in reset.
    assign fifo_read  = read_c & ~reset;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign word_count = count_q;

endmodule
